// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified single-port word memory serving fetch and data requests
// Data requests win arbitration; reads capture the pre-write word, ready pulses after LATENCY cycles.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_req,
  input  logic [31:0] instruction_addr,
  output logic [31:0] instruction_read,
  output logic        instruction_ready,
  input  logic        data_read_valid,
  input  logic        data_write_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic [3:0]  data_write_byte,
  output logic [31:0] data_read,
  output logic        data_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [2:0] LP_LOAD = 3'(LATENCY - 1);

  logic [31:0] r_mem [0:(1 << ADDR_WIDTH) - 1];

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_src_data;
  logic [31:0] r_resp;
  logic [31:0] r_iread;
  logic [31:0] r_dread;
  logic        r_iready;
  logic        r_dready;

  logic                  w_data_req;
  logic                  w_accept;
  logic                  w_we;
  logic [31:0]           w_addr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic                  w_unused;

  assign w_data_req = data_read_valid | data_write_valid;
  assign w_accept   = (r_state == IDLE) && !reset && (w_data_req || instruction_req);
  assign w_addr     = w_data_req ? data_addr : instruction_addr;
  assign w_idx      = w_addr[ADDR_WIDTH+1:2];
  assign w_we       = w_accept && data_write_valid;
  assign w_rd_word  = r_mem[w_idx];
  // Byte offset and high address bits are dropped, so the memory aliases.
  assign w_unused   = ^{w_addr[31:ADDR_WIDTH+2], w_addr[1:0]};

  // Kept out of the reset block: contents survive reset and writes commit at acceptance.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_write_byte[b]) r_mem[w_idx][8*b +: 8] <= data_write[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_src_data <= 1'b0;
      r_resp     <= 32'd0;
      r_iread    <= 32'd0;
      r_dread    <= 32'd0;
      r_iready   <= 1'b0;
      r_dready   <= 1'b0;
    end else begin
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_src_data <= w_data_req;
            r_resp     <= w_rd_word;
            r_cnt      <= LP_LOAD;
            if (LP_LOAD == 3'd0) begin
              r_state <= RESP;
              if (w_data_req) begin
                r_dready <= 1'b1;
                r_dread  <= w_rd_word;
              end else begin
                r_iready <= 1'b1;
                r_iread  <= w_rd_word;
              end
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= RESP;
            if (r_src_data) begin
              r_dready <= 1'b1;
              r_dread  <= r_resp;
            end else begin
              r_iready <= 1'b1;
              r_iread  <= r_resp;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instruction_read  = r_iread;
  assign instruction_ready = r_iready;
  assign data_read         = r_dread;
  assign data_ready        = r_dready;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder at LATENCY 1, 2 and 3
// Instance k runs with LATENCY k+1; each instance has its own stimulus signals.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        ireq  [3];
  logic [31:0] iaddr [3];
  logic        drv   [3];
  logic        dwv   [3];
  logic [31:0] daddr [3];
  logic [31:0] dwd   [3];
  logic [3:0]  dbe   [3];
  wire  [31:0] ird   [3];
  wire         irdy  [3];
  wire  [31:0] drd   [3];
  wire         drdy  [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.ADDR_WIDTH(10), .LATENCY(g + 1)) u_dut (
      .clk              (clk),
      .reset            (rst[g]),
      .instruction_req  (ireq[g]),
      .instruction_addr (iaddr[g]),
      .instruction_read (ird[g]),
      .instruction_ready(irdy[g]),
      .data_read_valid  (drv[g]),
      .data_write_valid (dwv[g]),
      .data_addr        (daddr[g]),
      .data_write       (dwd[g]),
      .data_write_byte  (dbe[g]),
      .data_read        (drd[g]),
      .data_ready       (drdy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one data request from an IDLE cycle; lat is the cycle count to data_ready, -1 on timeout.
  task automatic data_txn(input int k, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic [31:0] rdata);
    tick();
    drv[k] = rd; dwv[k] = wr; daddr[k] = a; dwd[k] = wd; dbe[k] = be;
    lat = -1;
    rdata = 32'hxxxxxxxx;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (drdy[k]) begin
        lat = c;
        rdata = drd[k];
        break;
      end
    end
    drv[k] = 1'b0; dwv[k] = 1'b0;
  endtask

  task automatic fetch_txn(input int k, input logic [31:0] a, output int lat, output logic [31:0] rdata);
    tick();
    ireq[k] = 1'b1; iaddr[k] = a;
    lat = -1;
    rdata = 32'hxxxxxxxx;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (irdy[k]) begin
        lat = c;
        rdata = ird[k];
        break;
      end
    end
    ireq[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; ireq[k] = 1'b1; iaddr[k] = 32'h0; drv[k] = 1'b1; dwv[k] = 1'b0;
      daddr[k] = 32'h0; dwd[k] = 32'h0; dbe[k] = 4'h0;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if ({irdy[k], drdy[k], ird[k], drd[k]} !== 66'd0) begin
          miscompares++;
          $display("FAIL reset_outputs inst%0d cyc%0d: got %h expected 0", k, c, {irdy[k], drdy[k], ird[k], drd[k]});
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      ireq[k] = 1'b0; drv[k] = 1'b0; rst[k] = 1'b0;
    end
  endtask

  task automatic test_write_fetch();
    int lat;
    logic [31:0] v;
    data_txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, v);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL write_latency: got %0d expected 1", lat); end
    fetch_txn(0, 32'h10, lat, v);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL fetch_latency: got %0d expected 1", lat); end
    vectors++;
    if (v !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_word: got %h expected deadbeef", v); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [31:0] v;
    data_txn(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0100, lat, v);
    vectors++;
    if (v !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lane_write_old_word: got %h expected deadbeef", v); end
    data_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, v);
    vectors++;
    if (v !== 32'hDE22BEEF) begin miscompares++; $display("FAIL lane_merge: got %h expected de22beef", v); end
    data_txn(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, v);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL noop_write_ready: got %0d expected 1", lat); end
    data_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, v);
    vectors++;
    if (v !== 32'hDE22BEEF) begin miscompares++; $display("FAIL noop_write_unchanged: got %h expected de22beef", v); end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] v;
    data_txn(0, 1'b1, 1'b0, 32'h1013, 32'h0, 4'b0000, lat, v);
    vectors++;
    if (v !== 32'hDE22BEEF) begin miscompares++; $display("FAIL alias_1013: got %h expected de22beef", v); end
    fetch_txn(0, 32'hFFFF_F012, lat, v);
    vectors++;
    if (v !== 32'hDE22BEEF) begin miscompares++; $display("FAIL alias_fetch_high: got %h expected de22beef", v); end
  endtask

  task automatic test_read_write_together();
    int lat;
    logic [31:0] v;
    data_txn(0, 1'b0, 1'b1, 32'h20, 32'h00000005, 4'b1111, lat, v);
    data_txn(0, 1'b1, 1'b1, 32'h20, 32'hAAAAAAAA, 4'b1111, lat, v);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL rw_latency: got %0d expected 1", lat); end
    vectors++;
    if (v !== 32'h00000005) begin miscompares++; $display("FAIL rw_old_word: got %h expected 00000005", v); end
    data_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, lat, v);
    vectors++;
    if (v !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL rw_new_word: got %h expected aaaaaaaa", v); end
  endtask

  task automatic test_arbitration();
    int lat;
    logic [31:0] v;
    int d_cyc = -1;
    int i_cyc = -1;
    logic both = 1'b0;
    logic [31:0] dv = 32'h0;
    logic [31:0] iv = 32'h0;
    data_txn(1, 1'b0, 1'b1, 32'h0, 32'hCAFE0001, 4'b1111, lat, v);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL l2_write_latency: got %0d expected 2", lat); end
    data_txn(1, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'b1111, lat, v);
    tick();
    drv[1] = 1'b1; daddr[1] = 32'h10; ireq[1] = 1'b1; iaddr[1] = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (drdy[1] && irdy[1]) both = 1'b1;
      if (drdy[1] && d_cyc < 0) begin d_cyc = c; dv = drd[1]; drv[1] = 1'b0; end
      if (irdy[1] && i_cyc < 0) begin i_cyc = c; iv = ird[1]; ireq[1] = 1'b0; end
    end
    drv[1] = 1'b0; ireq[1] = 1'b0;
    vectors++;
    if (d_cyc !== 2) begin miscompares++; $display("FAIL arb_data_cycle: got %0d expected 2", d_cyc); end
    vectors++;
    if (i_cyc !== 5) begin miscompares++; $display("FAIL arb_fetch_cycle: got %0d expected 5", i_cyc); end
    vectors++;
    if (both !== 1'b0) begin miscompares++; $display("FAIL arb_both_ready: got %b expected 0", both); end
    vectors++;
    if (dv !== 32'h0BADF00D) begin miscompares++; $display("FAIL arb_data_word: got %h expected 0badf00d", dv); end
    vectors++;
    if (iv !== 32'hCAFE0001) begin miscompares++; $display("FAIL arb_fetch_word: got %h expected cafe0001", iv); end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [31:0] v;
    logic seen = 1'b0;
    data_txn(2, 1'b0, 1'b1, 32'h34, 32'h00000055, 4'b1111, lat, v);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL l3_write_latency: got %0d expected 3", lat); end
    data_txn(2, 1'b1, 1'b0, 32'h34, 32'h0, 4'b0000, lat, v);
    fetch_txn(2, 32'h34, lat, v);
    vectors++;
    if (v !== 32'h00000055) begin miscompares++; $display("FAIL l3_fetch_word: got %h expected 00000055", v); end
    tick();
    dwv[2] = 1'b1; daddr[2] = 32'h30; dwd[2] = 32'h12345678; dbe[2] = 4'b1111;
    tick();
    dwv[2] = 1'b0;
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    vectors++;
    if ({irdy[2], drdy[2], ird[2], drd[2]} !== 66'd0) begin
      miscompares++;
      $display("FAIL midop_reset_outputs: got %h expected 0", {irdy[2], drdy[2], ird[2], drd[2]});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (drdy[2] || irdy[2]) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL midop_no_ready: got %b expected 0", seen); end
    data_txn(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, lat, v);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    vectors++;
    if (v !== 32'h12345678) begin miscompares++; $display("FAIL post_reset_word: got %h expected 12345678", v); end
  endtask

  initial begin
    test_reset();
    test_write_fetch();
    test_byte_lanes();
    test_alias();
    test_read_write_together();
    test_arbitration();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
